// File: rtl/user_gpio_cfg_seq.sv
// Command-table sequencer that programs the user GPIO block as an APB4 master.
// A small command RAM holds register writes with post-write delays and DI polls
// with a retry budget; start_i walks the table from index 0.
module user_gpio_cfg_seq #(
  parameter int unsigned NUM_CMD   = 8,
  parameter int unsigned GPIO_NUM  = 8,
  parameter int unsigned TICK_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int unsigned CMD_W    = 2 + 3 + TICK_W + GPIO_NUM,
  localparam int unsigned AW       = $clog2(NUM_CMD)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_we_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [CMD_W-1:0] cmd_data_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [AW-1:0]    pc_o,
  output logic             psel_o,
  output logic             penable_o,
  output logic             pwrite_o,
  output logic [31:0]      paddr_o,
  output logic [31:0]      pwdata_o,
  input  logic [31:0]      prdata_i,
  input  logic             pready_i,
  input  logic             pslverr_i
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StSetup  = 3'd2;
  localparam logic [2:0] StAccess = 3'd3;
  localparam logic [2:0] StWait   = 3'd4;

  localparam logic [1:0] OpEnd   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;

  logic [CMD_W-1:0]    mem_q [NUM_CMD];

  logic [2:0]          state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [GPIO_NUM-1:0] mask_q, mask_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                abort_pend_q, abort_pend_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [CMD_W-1:0]    cmd_word;
  logic [1:0]          fld_op;
  logic [2:0]          fld_reg;
  logic [TICK_W-1:0]   fld_arg;
  logic [GPIO_NUM-1:0] fld_data;
  logic                poll_match;
  logic                last_cmd;
  logic                go_next;
  logic                abort_seen;

  assign cmd_word   = mem_q[pc_q];
  assign fld_op     = cmd_word[CMD_W-1 -: 2];
  assign fld_reg    = cmd_word[CMD_W-3 -: 3];
  assign fld_arg    = cmd_word[GPIO_NUM +: TICK_W];
  assign fld_data   = cmd_word[GPIO_NUM-1:0];
  assign poll_match = (prdata_i[GPIO_NUM-1:0] & mask_q) == mask_q;
  assign last_cmd   = (pc_q == AW'(NUM_CMD - 1));
  assign abort_seen = abort_i | abort_pend_q;

  // Only the GPIO-wide slice of read data is compared.
  if (GPIO_NUM < 32) begin : gen_unused_prdata
    logic unused_prdata;
    assign unused_prdata = ^prdata_i[31:GPIO_NUM];
  end

  // Command RAM: writable only while idle, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (cmd_we_i && (state_q == StIdle)) begin
      mem_q[cmd_addr_i] <= cmd_data_i;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    err_d        = err_q;
    go_next      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d        = 1'b0;
          pc_d         = '0;
          abort_pend_d = 1'b0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (fld_op == OpEnd) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if ((fld_op == OpWrite) || (fld_op == OpPoll)) begin
          paddr_d  = BASE_ADDR + {27'd0, fld_reg, 2'b00};
          pwrite_d = (fld_op == OpWrite);
          pwdata_d = (fld_op == OpWrite) ? 32'(fld_data) : 32'd0;
          cnt_d    = fld_arg;
          mask_d   = fld_data;
          state_d  = StSetup;
        end else begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StSetup: begin
        state_d = abort_i ? StIdle : StAccess;
      end
      StAccess: begin
        // An abort during a transfer is remembered until the slave completes.
        if (abort_i) begin
          abort_pend_d = 1'b1;
        end
        if (pready_i) begin
          abort_pend_d = 1'b0;
          if (pslverr_i) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else if (abort_seen) begin
            state_d = StIdle;
          end else if (pwrite_q) begin
            if (cnt_q == '0) go_next = 1'b1;
            else             state_d = StWait;
          end else if (poll_match) begin
            go_next = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - TICK_W'(1);
            state_d = StSetup;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StWait: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q <= TICK_W'(1)) begin
          go_next = 1'b1;
        end else begin
          cnt_d = cnt_q - TICK_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // The last RAM slot finishing without an END still counts as success.
    if (go_next) begin
      if (last_cmd) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        pc_d    = pc_q + AW'(1);
        state_d = StFetch;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign pc_o      = pc_q;
  assign psel_o    = (state_q == StSetup) || (state_q == StAccess);
  assign penable_o = (state_q == StAccess);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_user_gpio_cfg_seq.sv
// Directed bench for user_gpio_cfg_seq with a small APB slave model and transfer log.
module tb_user_gpio_cfg_seq;

  localparam int CMD_W = 29;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cmd_we_i;
  logic [2:0]       cmd_addr_i;
  logic [CMD_W-1:0] cmd_data_i;
  logic             start_i;
  logic             abort_i;
  logic             busy_o, done_o, err_o;
  logic [2:0]       pc_o;
  logic             psel_o, penable_o, pwrite_o;
  logic [31:0]      paddr_o, pwdata_o, prdata_i;
  logic             pready_i, pslverr_i;

  int checks   = 0;
  int failures = 0;

  // Slave model controls, set by the stimulus.
  int slv_wait   = 0;
  int err_at     = 1000;
  int di_thresh  = 1000;

  // Transfer log written by the monitor.
  int          xfer_cnt = 0;
  int          cyc      = 0;
  int          wcnt     = 0;
  int          acc_len  = 0;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic        log_wr   [64];
  int          log_cyc  [64];
  int          log_acc  [64];
  logic [31:0] sa, sd;
  logic        sw;
  logic        stable_bad = 1'b0;

  user_gpio_cfg_seq dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_we_i   (cmd_we_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .pc_o       (pc_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  assign pready_i  = (wcnt == 0);
  assign pslverr_i = psel_o && penable_o && pready_i && (xfer_cnt == err_at);
  assign prdata_i  = (xfer_cnt >= di_thresh) ? 32'h0000_0008 : 32'hFFFF_FFF7;

  // Slave wait-state counter and transfer monitor.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (psel_o && !penable_o) begin
      wcnt <= slv_wait;
      sa   <= paddr_o;
      sd   <= pwdata_o;
      sw   <= pwrite_o;
    end else if (psel_o && penable_o) begin
      if (paddr_o !== sa || pwdata_o !== sd || pwrite_o !== sw) stable_bad <= 1'b1;
      if (wcnt != 0) begin
        wcnt    <= wcnt - 1;
        acc_len <= acc_len + 1;
      end else begin
        log_addr[xfer_cnt] <= paddr_o;
        log_data[xfer_cnt] <= pwdata_o;
        log_wr[xfer_cnt]   <= pwrite_o;
        log_cyc[xfer_cnt]  <= cyc;
        log_acc[xfer_cnt]  <= acc_len + 1;
        acc_len            <= 0;
        xfer_cnt           <= xfer_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [1:0] op, input logic [2:0] rg,
                      input logic [15:0] arg, input logic [7:0] data);
    cmd_addr_i = idx[2:0];
    cmd_data_i = {op, rg, arg, data};
    cmd_we_i   = 1'b1;
    @(negedge clk_i);
    cmd_we_i   = 1'b0;
  endtask

  // Pulse start; returns positioned in cycle 1 (the FETCH cycle).
  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Step until busy drops; n counts cycles after the start cycle.
  task automatic wait_idle(input int n0, output int n);
    n = n0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("timeout_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic check_xfer(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data, input logic wr);
    check({tag, "_addr"}, log_addr[idx], addr);
    check({tag, "_data"}, log_data[idx], data);
    check({tag, "_wr"},   32'(log_wr[idx]), 32'(wr));
  endtask

  initial begin
    int n;
    int base;
    rst_i      = 1'b1;
    cmd_we_i   = 1'b0;
    cmd_addr_i = '0;
    cmd_data_i = '0;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_pc", 32'(pc_o), 0);
    check("rst_psel", 32'(psel_o), 0);
    check("rst_penable", 32'(penable_o), 0);
    check("rst_pwrite", 32'(pwrite_o), 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);

    // Two writes then END, zero-wait slave
    load(0, 2'b01, 3'd1, 16'd0, 8'hFF);
    load(1, 2'b01, 3'd5, 16'd0, 8'hA5);
    load(2, 2'b00, 3'd0, 16'd0, 8'h00);
    base = xfer_cnt;
    do_start();
    check("t1_c1_busy", 32'(busy_o), 1);
    check("t1_c1_psel", 32'(psel_o), 0);
    @(negedge clk_i);
    check("t1_c2_psel", 32'(psel_o), 1);
    check("t1_c2_penable", 32'(penable_o), 0);
    check("t1_c2_paddr", paddr_o, 32'h4);
    @(negedge clk_i);
    check("t1_c3_penable", 32'(penable_o), 1);
    wait_idle(3, n);
    check("t1_done_cyc", 32'(n), 8);
    check("t1_done", 32'(done_o), 1);
    check("t1_err", 32'(err_o), 0);
    check("t1_pc", 32'(pc_o), 2);
    check("t1_count", 32'(xfer_cnt - base), 2);
    check_xfer("t1_x0", base, 32'h04, 32'hFF, 1'b1);
    check_xfer("t1_x1", base + 1, 32'h14, 32'hA5, 1'b1);
    @(negedge clk_i);
    check("t1_done_pulse", 32'(done_o), 0);

    // Post-write delay of 5 cycles
    load(0, 2'b01, 3'd5, 16'd5, 8'h01);
    load(1, 2'b01, 3'd5, 16'd0, 8'h00);
    base = xfer_cnt;
    do_start();
    wait_idle(1, n);
    check("t2_done_cyc", 32'(n), 13);
    check("t2_count", 32'(xfer_cnt - base), 2);
    check("t2_gap", 32'(log_cyc[base + 1] - log_cyc[base]), 8);
    check_xfer("t2_x1", base + 1, 32'h14, 32'h00, 1'b1);

    // Same table, slave inserts 3 wait states
    slv_wait = 3;
    base = xfer_cnt;
    do_start();
    wait_idle(1, n);
    check("t2b_done_cyc", 32'(n), 19);
    check("t2b_acc0", 32'(log_acc[base]), 4);
    check("t2b_acc1", 32'(log_acc[base + 1]), 4);
    check("t2b_stable", 32'(stable_bad), 0);
    slv_wait = 0;

    // Poll DI bit3, set before the third read
    load(0, 2'b10, 3'd6, 16'd3, 8'h08);
    load(1, 2'b00, 3'd0, 16'd0, 8'h00);
    base = xfer_cnt;
    di_thresh = base + 2;
    do_start();
    wait_idle(1, n);
    check("t3_done_cyc", 32'(n), 9);
    check("t3_done", 32'(done_o), 1);
    check("t3_reads", 32'(xfer_cnt - base), 3);
    check_xfer("t3_x0", base, 32'h18, 32'h0, 1'b0);

    // Poll never satisfied: four reads then error
    base = xfer_cnt;
    di_thresh = 1000;
    do_start();
    wait_idle(1, n);
    check("t3b_end_cyc", 32'(n), 10);
    check("t3b_reads", 32'(xfer_cnt - base), 4);
    check("t3b_err", 32'(err_o), 1);
    check("t3b_done", 32'(done_o), 0);
    check("t3b_pc", 32'(pc_o), 0);

    // Slave error on the second command
    load(0, 2'b01, 3'd1, 16'd0, 8'hFF);
    load(1, 2'b01, 3'd5, 16'd0, 8'h55);
    load(2, 2'b01, 3'd3, 16'd0, 8'h0F);
    load(3, 2'b00, 3'd0, 16'd0, 8'h00);
    base = xfer_cnt;
    err_at = base + 1;
    do_start();
    wait_idle(1, n);
    repeat (3) @(negedge clk_i);
    check("t4_err", 32'(err_o), 1);
    check("t4_pc", 32'(pc_o), 1);
    check("t4_count", 32'(xfer_cnt - base), 2);
    err_at = 1000;
    base = xfer_cnt;
    do_start();
    check("t4_err_cleared", 32'(err_o), 0);
    wait_idle(1, n);
    check("t4_rerun_count", 32'(xfer_cnt - base), 3);
    check("t4_rerun_done", 32'(done_o), 1);
    check("t4_rerun_err", 32'(err_o), 0);

    // Abort mid-access; start and RAM writes while busy are ignored
    load(0, 2'b01, 3'd1, 16'd0, 8'hFF);
    load(1, 2'b01, 3'd5, 16'd0, 8'h01);
    load(2, 2'b00, 3'd0, 16'd0, 8'h00);
    slv_wait = 4;
    base = xfer_cnt;
    do_start();
    @(negedge clk_i);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i    = 1'b0;
    start_i    = 1'b1;
    cmd_addr_i = 3'd1;
    cmd_data_i = '0;
    cmd_we_i   = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    cmd_we_i = 1'b0;
    wait_idle(5, n);
    check("t5_idle_cyc", 32'(n), 8);
    check("t5_count", 32'(xfer_cnt - base), 1);
    check("t5_done", 32'(done_o), 0);
    check("t5_err", 32'(err_o), 0);
    repeat (2) @(negedge clk_i);
    check("t5_no_restart", 32'(busy_o), 0);
    slv_wait = 0;
    base = xfer_cnt;
    do_start();
    wait_idle(1, n);
    check("t5_ram_kept", 32'(xfer_cnt - base), 2);
    check_xfer("t5_x1", base + 1, 32'h14, 32'h01, 1'b1);

    // Eight writes, no END
    for (int i = 0; i < 8; i++) load(i, 2'b01, 3'd5, 16'd0, 8'(i * 17));
    base = xfer_cnt;
    do_start();
    wait_idle(1, n);
    check("t6_done_cyc", 32'(n), 25);
    check("t6_done", 32'(done_o), 1);
    check("t6_count", 32'(xfer_cnt - base), 8);
    check("t6_pc", 32'(pc_o), 7);
    check_xfer("t6_x7", base + 7, 32'h14, 32'h77, 1'b1);

    // Illegal opcode at index 0
    load(0, 2'b11, 3'd1, 16'd0, 8'hFF);
    base = xfer_cnt;
    do_start();
    check("t7_c1_psel", 32'(psel_o), 0);
    wait_idle(1, n);
    check("t7_end_cyc", 32'(n), 2);
    check("t7_err", 32'(err_o), 1);
    check("t7_done", 32'(done_o), 0);
    check("t7_count", 32'(xfer_cnt - base), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
